simon_sound_sched: RTL and testbench

//   Speaker scheduler for the Simon game. Shares one square-wave speaker output between

---
 rtl/simon_sound_sched.sv | 198 +++++++++++++++++++
 tb/tb_simon_sound_sched.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/simon_sound_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// simon_sound_sched : priority speaker scheduler for tone/win/lose/high-score
// events, one square-wave note at a time.   Revision 1.0
// ---------------------------------------------------------------------------
module simon_sound_sched #(
  parameter int TICK_DIV   = 50000,
  parameter int HP0        = 56818,
  parameter int HP1        = 45454,
  parameter int HP2        = 37878,
  parameter int HP3        = 28409,
  parameter int HP_LOSE    = 113636,
  parameter int TONE_TICKS = 300,
  parameter int NOTE_TICKS = 150,
  parameter int LOSE_TICKS = 800,
  parameter int GAP_TICKS  = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tone_req,
  input  logic [1:0] tone_col,
  input  logic       win_req,
  input  logic       lose_req,
  input  logic       hs_req,
  input  logic       mute,
  output logic       spk,
  output logic       busy,
  output logic [2:0] evt_id
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam int HP_LOSE_SAT = (HP_LOSE > 65535) ? 65535 : HP_LOSE;

  localparam logic [15:0] C_HP0   = 16'(HP0);
  localparam logic [15:0] C_HP1   = 16'(HP1);
  localparam logic [15:0] C_HP2   = 16'(HP2);
  localparam logic [15:0] C_HP3   = 16'(HP3);
  localparam logic [15:0] C_HPL   = 16'(HP_LOSE_SAT);
  localparam logic [15:0] C_TONE  = 16'(TONE_TICKS);
  localparam logic [15:0] C_NOTE  = 16'(NOTE_TICKS);
  localparam logic [15:0] C_LOSE  = 16'(LOSE_TICKS);
  localparam logic [15:0] C_GAP   = 16'(GAP_TICKS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam logic [2:0] EV_NONE = 3'd0;
  localparam logic [2:0] EV_TONE = 3'd1;
  localparam logic [2:0] EV_WIN  = 3'd2;
  localparam logic [2:0] EV_LOSE = 3'd3;
  localparam logic [2:0] EV_HS   = 3'd4;

  logic [1:0]    state, next_state;
  logic          pend_tone, pend_win, pend_lose, pend_hs;
  logic [1:0]    tone_col_q, cur_col;
  logic [2:0]    cur_evt, sel_evt, note_idx, last_idx;
  logic [15:0]   hp_cnt, ntick, cur_hp, dur;
  logic [TW-1:0] tick_cnt;
  logic          spk_raw;
  logic          any_pend, tick_wrap, note_done, gap_done, preempt, last_note;
  logic [1:0]    adv_state;

  function automatic logic [15:0] col_hp(input logic [1:0] c);
    case (c)
      2'd0:    col_hp = C_HP0;
      2'd1:    col_hp = C_HP1;
      2'd2:    col_hp = C_HP2;
      default: col_hp = C_HP3;
    endcase
  endfunction

  assign any_pend  = pend_tone | pend_win | pend_lose | pend_hs;
  assign tick_wrap = (tick_cnt == TICK_LAST);
  // A zero duration still ends at the first tick wrap because ntick+1 >= 0.
  assign note_done = (state == S_PLAY) && tick_wrap && (({1'b0, ntick} + 17'd1) >= {1'b0, dur});
  assign gap_done  = (state == S_GAP) && tick_wrap && (({1'b0, ntick} + 17'd1) >= {1'b0, C_GAP});
  assign preempt   = pend_lose && (cur_evt != EV_LOSE) && ((state == S_PLAY) || (state == S_GAP));
  assign last_note = (note_idx == last_idx);
  assign adv_state = !last_note ? S_PLAY : (any_pend ? S_LOAD : S_IDLE);

  always_comb begin
    sel_evt = EV_TONE;
    if (pend_lose)     sel_evt = EV_LOSE;
    else if (pend_win) sel_evt = EV_WIN;
    else if (pend_hs)  sel_evt = EV_HS;
  end

  always_comb begin
    cur_hp   = C_HP0;
    dur      = C_NOTE;
    last_idx = 3'd0;
    case (cur_evt)
      EV_TONE: begin cur_hp = col_hp(cur_col); dur = C_TONE; end
      EV_WIN:  begin cur_hp = col_hp(note_idx[1:0]); last_idx = 3'd2; end
      EV_LOSE: begin cur_hp = C_HPL; dur = C_LOSE; end
      EV_HS:   begin
        cur_hp   = col_hp((note_idx >= 3'd3) ? 2'd3 : note_idx[1:0]);
        last_idx = 3'd4;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (any_pend) next_state = S_LOAD;
      S_LOAD: next_state = S_PLAY;
      S_PLAY: begin
        if (preempt)        next_state = S_LOAD;
        else if (note_done) next_state = (GAP_TICKS > 0) ? S_GAP : adv_state;
      end
      default: begin
        if (preempt)       next_state = S_LOAD;
        else if (gap_done) next_state = adv_state;
      end
    endcase
  end

  always_comb begin
    spk    = spk_raw & ~mute;
    busy   = (state != S_IDLE) || any_pend;
    evt_id = EV_NONE;
    if (state == S_LOAD)      evt_id = sel_evt;
    else if (state != S_IDLE) evt_id = cur_evt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_tone  <= 1'b0;
      pend_win   <= 1'b0;
      pend_lose  <= 1'b0;
      pend_hs    <= 1'b0;
      tone_col_q <= 2'd0;
      cur_col    <= 2'd0;
      cur_evt    <= EV_NONE;
      note_idx   <= 3'd0;
      hp_cnt     <= 16'd0;
      ntick      <= 16'd0;
      tick_cnt   <= '0;
      spk_raw    <= 1'b0;
    end else begin
      // A request landing in the LOAD cycle of its own event re-arms it.
      pend_tone <= tone_req | (pend_tone & ~((state == S_LOAD) && (sel_evt == EV_TONE)));
      pend_win  <= win_req  | (pend_win  & ~((state == S_LOAD) && (sel_evt == EV_WIN)));
      pend_lose <= lose_req | (pend_lose & ~((state == S_LOAD) && (sel_evt == EV_LOSE)));
      pend_hs   <= hs_req   | (pend_hs   & ~((state == S_LOAD) && (sel_evt == EV_HS)));
      if (tone_req) tone_col_q <= tone_col;

      case (state)
        S_IDLE: cur_evt <= EV_NONE;
        S_LOAD: begin
          cur_evt  <= sel_evt;
          cur_col  <= tone_col_q;
          note_idx <= 3'd0;
          hp_cnt   <= 16'd0;
          ntick    <= 16'd0;
          tick_cnt <= '0;
          spk_raw  <= 1'b0;
        end
        default: begin
          if ((next_state != state) || note_done || gap_done) begin
            hp_cnt   <= 16'd0;
            ntick    <= 16'd0;
            tick_cnt <= '0;
            spk_raw  <= 1'b0;
            if (next_state == S_PLAY) note_idx <= note_idx + 3'd1;
          end else begin
            if (tick_wrap) begin
              tick_cnt <= '0;
              ntick    <= ntick + 16'd1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
            if (state == S_PLAY) begin
              if (hp_cnt == cur_hp - 16'd1) begin
                hp_cnt  <= 16'd0;
                spk_raw <= ~spk_raw;
              end else begin
                hp_cnt <= hp_cnt + 16'd1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_simon_sound_sched.sv
`default_nettype none
// Directed bench for simon_sound_sched with small timing parameters.
module tb_simon_sound_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tone_req = 1'b0, win_req = 1'b0, lose_req = 1'b0, hs_req = 1'b0, mute = 1'b0;
  logic [1:0] tone_col = 2'd0;
  logic       spk, busy;
  logic [2:0] evt_id;

  int n_tests = 0;
  int n_fail  = 0;

  simon_sound_sched #(
    .TICK_DIV(4), .HP0(2), .HP1(3), .HP2(4), .HP3(5), .HP_LOSE(8),
    .TONE_TICKS(3), .NOTE_TICKS(2), .LOSE_TICKS(4), .GAP_TICKS(1)
  ) dut (
    .clk(clk), .rst(rst), .tone_req(tone_req), .tone_col(tone_col),
    .win_req(win_req), .lose_req(lose_req), .hs_req(hs_req), .mute(mute),
    .spk(spk), .busy(busy), .evt_id(evt_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       req;
    logic [1:0] col;
    logic       exp_spk;
    logic       exp_busy;
    logic [2:0] exp_evt;
  } vec_t;

  // Entry i is applied at edge i and checked just after it (tone col2, HP=4).
  vec_t tbl [20] = '{
    '{1'b1, 2'd2, 1'b0, 1'b1, 3'd0},  // 0  pending, still IDLE
    '{1'b0, 2'd0, 1'b0, 1'b1, 3'd1},  // 1  LOAD
    '{1'b0, 2'd0, 1'b0, 1'b1, 3'd1},  // 2  PLAY starts
    '{1'b0, 2'd0, 1'b0, 1'b1, 3'd1},
    '{1'b0, 2'd0, 1'b0, 1'b1, 3'd1},
    '{1'b0, 2'd0, 1'b0, 1'b1, 3'd1},
    '{1'b0, 2'd0, 1'b1, 1'b1, 3'd1},  // 6  first rise
    '{1'b0, 2'd0, 1'b1, 1'b1, 3'd1},
    '{1'b0, 2'd0, 1'b1, 1'b1, 3'd1},
    '{1'b0, 2'd0, 1'b1, 1'b1, 3'd1},
    '{1'b0, 2'd0, 1'b0, 1'b1, 3'd1},  // 10 fall
    '{1'b0, 2'd0, 1'b0, 1'b1, 3'd1},
    '{1'b0, 2'd0, 1'b0, 1'b1, 3'd1},
    '{1'b0, 2'd0, 1'b0, 1'b1, 3'd1},
    '{1'b0, 2'd0, 1'b0, 1'b1, 3'd1},  // 14 GAP
    '{1'b0, 2'd0, 1'b0, 1'b1, 3'd1},
    '{1'b0, 2'd0, 1'b0, 1'b1, 3'd1},
    '{1'b0, 2'd0, 1'b0, 1'b1, 3'd1},
    '{1'b0, 2'd0, 1'b0, 1'b0, 3'd0},  // 18 IDLE
    '{1'b0, 2'd0, 1'b0, 1'b0, 3'd0}
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    int run_id [8];
    int run_len[8];
    int nruns;
    logic [2:0] prev;
    logic done;

    #2;
    chk("reset_spk", spk, 0);
    chk("reset_busy", busy, 0);
    chk("reset_evt", evt_id, 0);
    step(); step();
    #2 rst = 1'b0;
    step();
    chk("post_reset_busy", busy, 0);

    // Single tone, unmuted then muted: identical busy/evt timing, spk gated.
    for (int m = 0; m < 2; m++) begin
      mute = m[0];
      for (int i = 0; i < 20; i++) begin
        tone_req = tbl[i].req;
        tone_col = tbl[i].col;
        step();
        tone_req = 1'b0;
        chk($sformatf("tone m%0d v%0d spk", m, i), spk, tbl[i].exp_spk & ~m[0]);
        chk($sformatf("tone m%0d v%0d busy", m, i), busy, tbl[i].exp_busy);
        chk($sformatf("tone m%0d v%0d evt", m, i), evt_id, tbl[i].exp_evt);
      end
    end
    mute = 1'b0;

    // win+hs+tone together: win(37 cycles) -> hs(61) -> tone(17) back to back.
    win_req = 1'b1; hs_req = 1'b1; tone_req = 1'b1; tone_col = 2'd1;
    step();
    win_req = 1'b0; hs_req = 1'b0; tone_req = 1'b0;
    chk("multi_first_busy", busy, 1);
    chk("multi_first_evt", evt_id, 0);
    nruns = 0; prev = 3'd0; done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      step();
      if (evt_id == 3'd0) begin
        done = 1'b1;
      end else if (evt_id != prev) begin
        if (nruns < 8) begin
          run_id[nruns]  = int'(evt_id);
          run_len[nruns] = 1;
        end
        nruns++;
      end else if (nruns > 0 && nruns <= 8) begin
        run_len[nruns-1]++;
      end
      prev = evt_id;
    end
    chk("multi_done", done, 1);
    chk("multi_nruns", nruns, 3);
    if (nruns == 3) begin
      chk("multi_id0", run_id[0], 2);
      chk("multi_len0", run_len[0], 37);
      chk("multi_id1", run_id[1], 4);
      chk("multi_len1", run_len[1], 61);
      chk("multi_id2", run_id[2], 1);
      chk("multi_len2", run_len[2], 17);
    end
    chk("multi_end_busy", busy, 0);

    // hs pre-empted by lose during note 2 (lose_req sampled at edge 28).
    hs_req = 1'b1;
    step();
    hs_req = 1'b0;
    for (int e = 1; e <= 55; e++) begin
      if (e == 28) lose_req = 1'b1;
      step();
      lose_req = 1'b0;
      if (e == 27) chk("pre_hs_evt", evt_id, 4);
      if (e == 28) chk("pre_still_hs", evt_id, 4);
      if (e == 29) chk("pre_load_evt", evt_id, 3);
      if (e == 37) chk("pre_spk_e37", spk, 0);
      if (e == 38) chk("pre_spk_e38", spk, 1);
      if (e == 45) chk("pre_spk_e45", spk, 1);
      if (e == 45) chk("pre_evt_e45", evt_id, 3);
      if (e == 46) chk("pre_spk_e46", spk, 0);
      if (e == 49) chk("pre_evt_e49", evt_id, 3);
      if (e == 50) chk("pre_evt_e50", evt_id, 0);
      if (e == 55) chk("pre_busy_e55", busy, 0);
    end

    // Three tone requests during a win: one tone, last colour (HP=5).
    win_req = 1'b1;
    step();
    win_req = 1'b0;
    for (int e = 1; e <= 58; e++) begin
      if (e == 5) begin tone_req = 1'b1; tone_col = 2'd0; end
      if (e == 6) begin tone_req = 1'b1; tone_col = 2'd1; end
      if (e == 7) begin tone_req = 1'b1; tone_col = 2'd3; end
      step();
      tone_req = 1'b0;
      if (e == 37) chk("tw_win_end_evt", evt_id, 2);
      if (e == 38) chk("tw_tone_evt", evt_id, 1);
      if (e == 43) chk("tw_spk_e43", spk, 0);
      if (e == 44) chk("tw_spk_e44", spk, 1);
      if (e == 48) chk("tw_spk_e48", spk, 1);
      if (e == 49) chk("tw_spk_e49", spk, 0);
      if (e == 54) chk("tw_evt_e54", evt_id, 1);
      if (e == 55) chk("tw_evt_e55", evt_id, 0);
      if (e == 58) chk("tw_busy_e58", busy, 0);
    end

    // Reset mid-PLAY with a win pending.
    tone_req = 1'b1; tone_col = 2'd2;
    step();
    tone_req = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      if (e == 4) win_req = 1'b1;
      step();
      win_req = 1'b0;
    end
    chk("rst_pre_spk", spk, 1);
    chk("rst_pre_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_spk", spk, 0);
    chk("rst_busy", busy, 0);
    chk("rst_evt", evt_id, 0);
    #3 rst = 1'b0;
    begin
      int bad;
      bad = 0;
      for (int c = 0; c < 30; c++) begin
        step();
        if (busy !== 1'b0 || evt_id !== 3'd0) bad++;
      end
      chk("rst_no_events", bad, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
